// File: rtl/key_event_pkg.sv
// Shared widths, repeat-FSM state type and the lowest-set-bit encoder for key_event.
package key_event_pkg;

  localparam int unsigned KEY_W   = 12;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned COUNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [CODE_W-1:0] lsb_index(input logic [KEY_W-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = int'(KEY_W) - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_if.sv
// Key/code bus between the scanner/consumer side (master) and key_event (slave).
interface key_event_if;
  import key_event_pkg::*;

  logic [KEY_W-1:0]   key;
  logic [KEY_W-1:0]   key_held;
  logic [KEY_W-1:0]   key_press;
  logic               code_valid;
  logic [CODE_W-1:0]  code;
  logic               code_ready;
  logic               overflow;
  logic [COUNT_W-1:0] fifo_count;

  modport master (
    output key, code_ready,
    input  key_held, key_press, code_valid, code, overflow, fifo_count
  );

  modport slave (
    input  key, code_ready,
    output key_held, key_press, code_valid, code, overflow, fifo_count
  );

endinterface

// File: rtl/key_event_fifo.sv
// key_fifo: synchronous code queue; simultaneous push/pop honoured even when full,
// a push into a full queue without a pop is dropped and pulses drop_o.
module key_fifo
  import key_event_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = CODE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [DATA_W-1:0]  push_data_i,
  input  logic               pop_i,
  output logic               empty_o,
  output logic [DATA_W-1:0]  head_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               drop_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [COUNT_W-1:0] count_q;
  logic               drop_q;
  logic               full;
  logic               do_pop;
  logic               do_push;

  assign full    = (count_q == COUNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= push_i && !do_push;
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/key_event.sv
// Keypad event stage: debounce, press edge detect, lowest-bit encode, code FIFO.
// Define KEY_REPEAT_EN to build the auto-repeat engine for the held key.
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD   = 100,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic        clk,
  input logic        reset,
  key_event_if.slave bus
);

  localparam int unsigned     DB_W    = 8;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0]  raw_q;
  logic [KEY_W-1:0]  held_q, held_d;
  logic [KEY_W-1:0]  press_q, press_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_push_c;
  logic [CODE_W-1:0] press_code_c;
  logic              push_c;
  logic [CODE_W-1:0] push_code_c;
  logic              fifo_empty;

  // Whole-vector debounce: any change in the raw vector restarts the count.
  always_comb begin
    db_cnt_d = db_cnt_q;
    held_d   = held_q;
    if (bus.key != raw_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_LAST) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    if ((db_cnt_q == DB_LAST) && (raw_q != held_q)) held_d = raw_q;
    press_d = held_d & ~held_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q    <= '0;
      db_cnt_q <= '0;
      held_q   <= '0;
      press_q  <= '0;
    end else begin
      raw_q    <= bus.key;
      db_cnt_q <= db_cnt_d;
      held_q   <= held_d;
      press_q  <= press_d;
    end
  end

  assign press_push_c = |press_q;
  assign press_code_c = lsb_index(press_q);

`ifdef KEY_REPEAT_EN
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] RD_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RP_LAST = TMR_W'(REPEAT_PERIOD - 1);

  rep_state_e        state_q, state_d;
  logic [CODE_W-1:0] trk_q, trk_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              rep_push_c;

  // A fresh press always wins and restarts the delay, so the two pushes never collide.
  always_comb begin
    state_d    = state_q;
    trk_d      = trk_q;
    tmr_d      = tmr_q + 1'b1;
    rep_push_c = 1'b0;
    if (press_push_c) begin
      state_d = DELAY;
      trk_d   = press_code_c;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: tmr_d = '0;
        DELAY: begin
          if (!held_q[trk_q]) begin
            state_d = IDLE;
          end else if (tmr_q == RD_LAST) begin
            rep_push_c = 1'b1;
            state_d    = REPEAT;
            tmr_d      = '0;
          end
        end
        REPEAT: begin
          if (!held_q[trk_q]) begin
            state_d = IDLE;
          end else if (tmr_q == RP_LAST) begin
            rep_push_c = 1'b1;
            tmr_d      = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      trk_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      trk_q   <= trk_d;
      tmr_q   <= tmr_d;
    end
  end

  assign push_c      = press_push_c | rep_push_c;
  assign push_code_c = press_push_c ? press_code_c : trk_q;
`else
  // Repeat parameters have no effect here; an empty block marks a zero-length setting.
  if ((REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_repeat_cfg_zero
  end

  assign push_c      = press_push_c;
  assign push_code_c = press_code_c;
`endif

  key_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (CODE_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_c),
    .push_data_i (push_code_c),
    .pop_i       (bus.code_ready),
    .empty_o     (fifo_empty),
    .head_o      (bus.code),
    .count_o     (bus.fifo_count),
    .drop_o      (bus.overflow)
  );

  assign bus.key_held   = held_q;
  assign bus.key_press  = press_q;
  assign bus.code_valid = !fifo_empty;

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: directed table, corner sequences and random
// stimulus, all compared against a cycle-level reference model of the key rules.
`timescale 1ns/1ps
module tb_key_event;
  import key_event_pkg::*;

  localparam int unsigned DB    = 4;
  localparam int unsigned RD    = 10;
  localparam int unsigned RP    = 3;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  key_event_if bus();

  key_event #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [KEY_W-1:0] m_hist[$];
  logic [KEY_W-1:0] m_held = '0;
  logic [KEY_W-1:0] m_press = '0;
  int               m_q[$];
  bit               m_ovf = 1'b0;
  bit               m_act = 1'b0;
  int               m_trk = 0;
  int               m_next = 0;
  int               cyc = 0;

  function automatic int lsb(input logic [KEY_W-1:0] v);
    for (int i = 0; i < int'(KEY_W); i++) if (v[i]) return i;
    return 0;
  endfunction

  // Held value follows the raw input once DB consecutive samples agree.
  task automatic model_step();
    bit push;
    int pcode;
    bit pop;
    bit all_eq;
    logic [KEY_W-1:0] new_held;
    if (reset) begin
      m_hist = {12'h000};
      m_held = '0;
      m_press = '0;
      m_q.delete();
      m_ovf = 1'b0;
      m_act = 1'b0;
    end else begin
      push = 1'b0;
      pcode = 0;
      if (m_press != '0) begin
        push = 1'b1;
        pcode = lsb(m_press);
`ifdef KEY_REPEAT_EN
        m_act = 1'b1;
        m_trk = pcode;
        m_next = cyc + int'(RD);
`endif
      end
`ifdef KEY_REPEAT_EN
      else if (m_act) begin
        if (!m_held[m_trk]) m_act = 1'b0;
        else if (cyc == m_next) begin
          push = 1'b1;
          pcode = m_trk;
          m_next = m_next + int'(RP);
        end
      end
`endif
      pop = bus.code_ready && (m_q.size() > 0);
      m_ovf = push && !pop && (m_q.size() == int'(DEPTH));
      if (pop) void'(m_q.pop_front());
      if (push && !m_ovf) m_q.push_back(pcode);

      all_eq = (m_hist.size() == int'(DB));
      foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
      new_held = all_eq ? m_hist[$] : m_held;
      m_press = new_held & ~m_held;
      m_held = new_held;
      m_hist.push_back(bus.key);
      if (m_hist.size() > int'(DB)) void'(m_hist.pop_front());
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("m_held",  32'(bus.key_held),   32'(m_held));
      check("m_press", 32'(bus.key_press),  32'(m_press));
      check("m_valid", 32'(bus.code_valid), 32'(m_q.size() != 0));
      check("m_code",  32'(bus.code),       (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      check("m_ovf",   32'(bus.overflow),   32'(m_ovf));
      check("m_count", 32'(bus.fifo_count), 32'(m_q.size()));
    end
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] press;
    int               code;
  } vec_t;

  vec_t tbl[6];
  int   got[$];
  int   exp_rep[8];
  int   ovf_codes[5];
  int   fill_codes[4];
  logic [KEY_W-1:0] rk;

  initial begin
    tbl[0] = '{key: 12'h020, press: 12'h020, code: 5};
    tbl[1] = '{key: 12'h084, press: 12'h084, code: 2};
    tbl[2] = '{key: 12'h800, press: 12'h800, code: 11};
    tbl[3] = '{key: 12'h001, press: 12'h001, code: 0};
    tbl[4] = '{key: 12'hFFF, press: 12'hFFF, code: 0};
    tbl[5] = '{key: 12'h600, press: 12'h600, code: 9};
    exp_rep = '{0, 10, 13, 16, 19, 22, 25, 28};
    ovf_codes = '{1, 2, 3, 4, 6};
    fill_codes = '{7, 8, 10, 11};

    bus.key = '0;
    bus.code_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    check("rst_held",  32'(bus.key_held),   32'd0);
    check("rst_press", 32'(bus.key_press),  32'd0);
    check("rst_valid", 32'(bus.code_valid), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    reset = 1'b0;
    step();

    // glitch shorter than the debounce window
    bus.key = 12'h020;
    for (int i = 0; i < 3; i++) step();
    bus.key = '0;
    for (int i = 0; i < 8; i++) begin
      check("glitch_held",  32'(bus.key_held),   32'd0);
      check("glitch_press", 32'(bus.key_press),  32'd0);
      check("glitch_valid", 32'(bus.code_valid), 32'd0);
      step();
    end

    // table: press timing, encode and one-cycle code with ready high
    bus.code_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      bus.key = tbl[v].key;
      for (int i = 0; i < 5; i++) step();
      check("tbl_held",  32'(bus.key_held),   32'(tbl[v].key));
      check("tbl_press", 32'(bus.key_press),  32'(tbl[v].press));
      step();
      check("tbl_press_off", 32'(bus.key_press),  32'd0);
      check("tbl_valid",     32'(bus.code_valid), 32'd1);
      check("tbl_code",      32'(bus.code),       32'(tbl[v].code));
      check("tbl_count",     32'(bus.fifo_count), 32'd1);
      bus.key = '0;
      step();
      check("tbl_valid_off", 32'(bus.code_valid), 32'd0);
      for (int i = 0; i < 8; i++) step();
    end

    // overflow: five presses with ready low
    bus.code_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.key = 12'(1) << ovf_codes[i];
      for (int j = 0; j < 6; j++) step();
      check("ovf_count", 32'(bus.fifo_count), (i == 4) ? 32'd4 : 32'(i + 1));
      check("ovf_pulse", 32'(bus.overflow),   (i == 4) ? 32'd1 : 32'd0);
      bus.key = '0;
      for (int j = 0; j < 7; j++) step();
    end
    bus.code_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop_code", 32'(bus.code), 32'(ovf_codes[i]));
      step();
    end
    check("ovf_drained", 32'(bus.code_valid), 32'd0);

    // full queue with a same-cycle pop: nothing dropped
    bus.code_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.key = 12'(1) << fill_codes[i];
      for (int j = 0; j < 6; j++) step();
      bus.key = '0;
      for (int j = 0; j < 7; j++) step();
    end
    bus.key = 12'h001;
    for (int j = 0; j < 5; j++) step();
    bus.code_ready = 1'b1;
    step();
    bus.code_ready = 1'b0;
    check("full_pp_count", 32'(bus.fifo_count), 32'd4);
    check("full_pp_ovf",   32'(bus.overflow),   32'd0);
    check("full_pp_head",  32'(bus.code),       32'd8);
    bus.key = '0;
    for (int j = 0; j < 7; j++) step();
    bus.code_ready = 1'b1;
    check("full_pp_q1", 32'(bus.code), 32'd8);
    step();
    check("full_pp_q2", 32'(bus.code), 32'd10);
    step();
    check("full_pp_q3", 32'(bus.code), 32'd11);
    step();
    check("full_pp_q4", 32'(bus.code), 32'd0);
    check("full_pp_q4v", 32'(bus.code_valid), 32'd1);
    step();
    check("full_pp_empty", 32'(bus.code_valid), 32'd0);

`ifdef KEY_REPEAT_EN
    // auto-repeat of key 9, released so key_held drops 30 cycles after the press push
    bus.code_ready = 1'b1;
    bus.key = 12'h200;
    for (int j = 0; j < 6; j++) step();
    got.delete();
    for (int t = 0; t < 45; t++) begin
      if (bus.code_valid) begin
        got.push_back(t);
        check("rep_code", 32'(bus.code), 32'd9);
      end
      if (t == 25) bus.key = '0;
      step();
    end
    check("rep_n", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("rep_offset", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_rep[i]));
    end
`endif

    // reset in the middle of a hold
    bus.code_ready = 1'b0;
    bus.key = 12'h200;
    for (int j = 0; j < 6; j++) step();
`ifdef KEY_REPEAT_EN
    for (int j = 0; j < 14; j++) step();
    check("mid_count", 32'(bus.fifo_count), 32'd3);
`else
    check("mid_count", 32'(bus.fifo_count), 32'd1);
`endif
    reset = 1'b1;
    step();
    check("mrst_held",  32'(bus.key_held),   32'd0);
    check("mrst_press", 32'(bus.key_press),  32'd0);
    check("mrst_valid", 32'(bus.code_valid), 32'd0);
    check("mrst_code",  32'(bus.code),       32'd0);
    check("mrst_count", 32'(bus.fifo_count), 32'd0);
    check("mrst_ovf",   32'(bus.overflow),   32'd0);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) step();
    check("mrst_early", 32'(bus.key_press), 32'd0);
    step();
    check("mrst_repress", 32'(bus.key_press), 32'h200);
    bus.key = '0;
    bus.code_ready = 1'b1;
    for (int j = 0; j < 10; j++) step();

    // random stimulus against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: rk = '0;
        1: rk = 12'(1) << $urandom_range(0, 11);
        2: rk = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
        default: rk = 12'($urandom_range(0, 4095));
      endcase
      bus.key = rk;
      for (int j = 0; j < int'($urandom_range(1, 22)); j++) begin
        bus.code_ready = ($urandom_range(0, 2) == 0);
        step();
      end
    end
    bus.key = '0;
    bus.code_ready = 1'b1;
    for (int j = 0; j < 12; j++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
